// File: rtl/resp_slot_sched.sv
// Response-slot scheduler: buffers read responses and a temperature value
// and presents one winner per two-cycle slot. Optional macro: RESP_SLOT_EDC_EN.

package resp_slot_pkg;
    typedef struct packed {
        logic [7:0]  tag;
        logic [23:0] data;
    } pkt_t;
endpackage

module resp_slot_sched
    import resp_slot_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  slot_phase,
    input  logic                  pkt_valid_in,
    input  logic                  pkt_retry_in,
    input  pkt_t                  pkt_in,
    input  logic [31:0]           edc_in,
    output logic                  pkt_ready,
    input  logic                  temp_req,
    input  logic [7:0]            temp_data_in,
    output logic                  temp_ack,
    output logic                  out_pkt_valid,
    output logic                  out_pkt_retry,
    output pkt_t                  out_pkt,
    output logic [31:0]           out_edc,
    output logic                  out_temp_valid,
    output logic [7:0]            out_temp_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                  overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        pkt_t        pkt;
        logic        retry;
`ifdef RESP_SLOT_EDC_EN
        logic [31:0] edc;
`endif
    } entry_t;

    typedef enum logic [1:0] {IDLE, S0, S1} state_t;

    state_t      state;
    state_t      state_nxt;
    entry_t      mem [DEPTH];
    entry_t      wr_entry;
    entry_t      rd_entry;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] level;
    logic [AW:0] level_nxt;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        temp_full;
    logic [7:0]  temp_q;
    logic        capture;
    logic [7:0]  starve_cnt;
    logic        arb;
    logic        force_temp;
    logic        win_pkt;
    logic        win_temp;
    logic        clr;

    assign level      = wr_ptr - rd_ptr;
    assign fifo_empty = (level == '0);
    assign fifo_level = level;
    assign push       = pkt_valid_in && pkt_ready;
    assign pop        = win_pkt;
    assign level_nxt  = level + (AW+1)'(push) - (AW+1)'(pop);
    assign rd_entry   = mem[rd_ptr[AW-1:0]];
    assign capture    = temp_req && !temp_full;

    // Assemble the FIFO entry from the handler inputs
    always_comb begin
        wr_entry       = '0;
        wr_entry.pkt   = pkt_in;
        wr_entry.retry = pkt_retry_in;
`ifdef RESP_SLOT_EDC_EN
        wr_entry.edc   = edc_in;
`endif
    end

`ifndef RESP_SLOT_EDC_EN
    logic unused_edc;
    assign unused_edc = ^edc_in;
    assign out_edc    = '0;
`endif

    // FIFO storage; contents are dropped on reset by clearing the pointers
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    // FIFO pointers, registered ready and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_ready <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            pkt_ready <= (level_nxt != (AW+1)'(DEPTH));
            if (pkt_valid_in && !pkt_ready)
                overflow <= 1'b1;
        end
    end

    // Single-entry temperature holder with capture acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_full <= 1'b0;
            temp_q    <= '0;
            temp_ack  <= 1'b0;
        end else begin
            temp_ack <= capture;
            if (capture) begin
                temp_full <= 1'b1;
                temp_q    <= temp_data_in;
            end else if (win_temp) begin
                temp_full <= 1'b0;
            end
        end
    end

    // Starvation counter: packet wins while temperature waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!temp_full || win_temp)
            starve_cnt <= '0;
        else if (win_pkt && starve_cnt != 8'(STARVE_MAX))
            starve_cnt <= starve_cnt + 8'd1;
    end

    // Slot FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Slot FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = (win_pkt || win_temp) ? S0 : IDLE;
            S0:      state_nxt = S1;
            S1:      state_nxt = (win_pkt || win_temp) ? S0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot FSM decode: arbitration and clear controls
    always_comb begin
        arb        = slot_phase && (state != S0);
        force_temp = temp_full && (starve_cnt == 8'(STARVE_MAX));
        win_temp   = arb && (force_temp || (fifo_empty && temp_full));
        win_pkt    = arb && !force_temp && !fifo_empty;
        clr        = (arb && !win_temp && !win_pkt)
                   || (state == S1 && !slot_phase);
    end

    // Slot output registers, held stable across S0 and S1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pkt_valid  <= 1'b0;
            out_pkt_retry  <= 1'b0;
            out_pkt        <= '0;
            out_temp_valid <= 1'b0;
            out_temp_data  <= '0;
`ifdef RESP_SLOT_EDC_EN
            out_edc        <= '0;
`endif
        end else if (win_pkt) begin
            out_pkt_valid  <= 1'b1;
            out_pkt_retry  <= rd_entry.retry;
            out_pkt        <= rd_entry.pkt;
            out_temp_valid <= 1'b0;
            out_temp_data  <= '0;
`ifdef RESP_SLOT_EDC_EN
            out_edc        <= rd_entry.edc;
`endif
        end else if (win_temp) begin
            out_pkt_valid  <= 1'b0;
            out_pkt_retry  <= 1'b0;
            out_pkt        <= '0;
            out_temp_valid <= 1'b1;
            out_temp_data  <= temp_q;
`ifdef RESP_SLOT_EDC_EN
            out_edc        <= '0;
`endif
        end else if (clr) begin
            out_pkt_valid  <= 1'b0;
            out_pkt_retry  <= 1'b0;
            out_pkt        <= '0;
            out_temp_valid <= 1'b0;
            out_temp_data  <= '0;
`ifdef RESP_SLOT_EDC_EN
            out_edc        <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_resp_slot_sched.sv
// Directed bench for resp_slot_sched: slots, full FIFO, starvation,
// temperature-only, phase loss and mid-slot reset.

module tb_resp_slot_sched;
    import resp_slot_pkg::*;

`ifdef RESP_SLOT_EDC_EN
    localparam bit EDC_ON = 1'b1;
`else
    localparam bit EDC_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        slot_phase;
    logic        pkt_valid_in;
    logic        pkt_retry_in;
    pkt_t        pkt_in;
    logic [31:0] edc_in;
    logic        pkt_ready;
    logic        temp_req;
    logic [7:0]  temp_data_in;
    logic        temp_ack;
    logic        out_pkt_valid;
    logic        out_pkt_retry;
    pkt_t        out_pkt;
    logic [31:0] out_edc;
    logic        out_temp_valid;
    logic [7:0]  out_temp_data;
    logic [2:0]  fifo_level;
    logic        overflow;

    logic [80:0] obs;
    logic [80:0] exp;
    bit          ovf_exp;
    int          vectors;
    int          miscompares;

    resp_slot_sched #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .slot_phase     (slot_phase),
        .pkt_valid_in   (pkt_valid_in),
        .pkt_retry_in   (pkt_retry_in),
        .pkt_in         (pkt_in),
        .edc_in         (edc_in),
        .pkt_ready      (pkt_ready),
        .temp_req       (temp_req),
        .temp_data_in   (temp_data_in),
        .temp_ack       (temp_ack),
        .out_pkt_valid  (out_pkt_valid),
        .out_pkt_retry  (out_pkt_retry),
        .out_pkt        (out_pkt),
        .out_edc        (out_edc),
        .out_temp_valid (out_temp_valid),
        .out_temp_data  (out_temp_data),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    assign obs = {out_pkt_valid, out_pkt_retry, out_pkt, out_edc,
                  out_temp_valid, out_temp_data, fifo_level,
                  pkt_ready, overflow, temp_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [80:0] pack(
        bit v, bit r, logic [31:0] p, logic [31:0] e,
        bit tv, logic [7:0] td, logic [2:0] l,
        bit rdy, bit ovf, bit ack);
        logic [31:0] ee;
        ee = EDC_ON ? e : 32'h0;
        return {v, r, p, ee, tv, td, l, rdy, ovf, ack};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        exp = pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", obs, exp);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_pkt_stream;
        logic [31:0] pk[3] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        bit          rt[3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ed[3] = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222};
        int          ph[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        int          ix[10] = '{-1, -1, 0, 0, 1, 1, 2, 2, -1, -1};
        int          lv[10] = '{1, 2, 2, 2, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            slot_phase   = (ph[i] != 0);
            pkt_valid_in = (i < 3);
            if (i < 3) begin
                pkt_in       = pk[i];
                pkt_retry_in = rt[i];
                edc_in       = ed[i];
            end
            tick();
            if (ix[i] >= 0)
                exp = pack(1, rt[ix[i]], pk[ix[i]], ed[ix[i]], 0, 0,
                           3'(lv[i]), 1, 0, 0);
            else
                exp = pack(0, 0, 0, 0, 0, 0, 3'(lv[i]), 1, 0, 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pkt_stream[%0d]: got %h expected %h",
                         i, obs, exp);
            end
        end
    endtask

    task automatic test_full_fifo;
        int lv[5]  = '{1, 2, 3, 4, 4};
        int rdy[5] = '{1, 1, 1, 0, 0};
        int of[5]  = '{0, 0, 0, 0, 1};
        int dx[10] = '{0, 0, 1, 1, 2, 2, 3, 3, -1, -1};
        int dl[10] = '{3, 3, 2, 2, 1, 1, 0, 0, 0, 0};
        slot_phase = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pkt_valid_in = 1'b1;
            pkt_in       = 32'hB000_0000 | i;
            pkt_retry_in = i[0];
            edc_in       = 32'hC0DE_0000 | i;
            tick();
            exp = pack(0, 0, 0, 0, 0, 0, 3'(lv[i]),
                       rdy[i] != 0, of[i] != 0, 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL full_push[%0d]: got %h expected %h",
                         i, obs, exp);
            end
        end
        ovf_exp      = 1'b1;
        pkt_valid_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            slot_phase = (i % 2 == 0);
            tick();
            if (dx[i] >= 0)
                exp = pack(1, dx[i][0], 32'hB000_0000 | dx[i],
                           32'hC0DE_0000 | dx[i], 0, 0,
                           3'(dl[i]), 1, ovf_exp, 0);
            else
                exp = pack(0, 0, 0, 0, 0, 0, 3'(dl[i]), 1, ovf_exp, 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL full_drain[%0d]: got %h expected %h",
                         i, obs, exp);
            end
        end
    endtask

    task automatic test_temp_only;
        int ph[5] = '{0, 1, 0, 1, 0};
        int tv[5] = '{0, 1, 1, 0, 0};
        int ak[5] = '{1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            slot_phase   = (ph[i] != 0);
            temp_req     = (i == 0);
            temp_data_in = 8'h3C;
            tick();
            exp = pack(0, 0, 0, 0, tv[i] != 0, (tv[i] != 0) ? 8'h3C : 8'h00,
                       0, 1, ovf_exp, ak[i] != 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL temp_only[%0d]: got %h expected %h",
                         i, obs, exp);
            end
        end
    endtask

    task automatic test_starvation;
        int k;
        int la;
        int lb;
        slot_phase   = 1'b0;
        pkt_valid_in = 1'b1;
        pkt_in       = 32'hE000_0000;
        pkt_retry_in = 1'b0;
        edc_in       = 32'h5EED_0000;
        temp_req     = 1'b1;
        temp_data_in = 8'h5A;
        tick();
        exp = pack(0, 0, 0, 0, 0, 0, 1, 1, ovf_exp, 1);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL starve_ack: got %h expected %h", obs, exp);
        end
        temp_req     = 1'b0;
        pkt_in       = 32'hE000_0001;
        pkt_retry_in = 1'b1;
        edc_in       = 32'h5EED_0001;
        tick();
        exp = pack(0, 0, 0, 0, 0, 0, 2, 1, ovf_exp, 0);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL starve_ack_drop: got %h expected %h", obs, exp);
        end
        for (int s = 1; s <= 12; s++) begin
            if (s <= 8) begin
                k = s - 1;
                la = 1;
                lb = 2;
            end else if (s == 9) begin
                k = -1;
                la = 2;
                lb = 2;
            end else if (s == 10) begin
                k = 8;
                la = 1;
                lb = 1;
            end else if (s == 11) begin
                k = 9;
                la = 0;
                lb = 0;
            end else begin
                k = -2;
                la = 0;
                lb = 0;
            end
            for (int h = 0; h < 2; h++) begin
                slot_phase   = (h == 0);
                pkt_valid_in = (h == 1) && (s <= 8);
                pkt_in       = 32'hE000_0000 | (s + 1);
                pkt_retry_in = (s + 1) % 2 != 0;
                edc_in       = 32'h5EED_0000 | (s + 1);
                tick();
                if (k >= 0)
                    exp = pack(1, k[0], 32'hE000_0000 | k,
                               32'h5EED_0000 | k, 0, 0,
                               3'((h == 0) ? la : lb), 1, ovf_exp, 0);
                else if (k == -1)
                    exp = pack(0, 0, 0, 0, 1, 8'h5A,
                               3'((h == 0) ? la : lb), 1, ovf_exp, 0);
                else
                    exp = pack(0, 0, 0, 0, 0, 0,
                               3'((h == 0) ? la : lb), 1, ovf_exp, 0);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL starve_slot%0d_c%0d: got %h expected %h",
                             s, h, obs, exp);
                end
            end
        end
        pkt_valid_in = 1'b0;
    endtask

    task automatic test_phase_loss;
        int ph[8] = '{0, 1, 0, 0, 0, 1, 0, 1};
        int pv[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
        int ix[8] = '{-1, 0, 0, -1, -1, 1, 1, -1};
        int lv[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            slot_phase   = (ph[i] != 0);
            pkt_valid_in = (pv[i] != 0);
            pkt_in       = 32'hF000_0000 | i;
            pkt_retry_in = 1'b1;
            edc_in       = 32'hDEAD_BEEF;
            tick();
            if (ix[i] >= 0)
                exp = pack(1, 1, 32'hF000_0000 | ix[i], 32'hDEAD_BEEF,
                           0, 0, 3'(lv[i]), 1, ovf_exp, 0);
            else
                exp = pack(0, 0, 0, 0, 0, 0, 3'(lv[i]), 1, ovf_exp, 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL phase_loss[%0d]: got %h expected %h",
                         i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_slot;
        slot_phase   = 1'b0;
        pkt_valid_in = 1'b1;
        pkt_in       = 32'hD000_0000;
        pkt_retry_in = 1'b1;
        edc_in       = 32'hDEAD_BEEF;
        tick();
        slot_phase   = 1'b1;
        pkt_in       = 32'hD000_0001;
        pkt_retry_in = 1'b0;
        tick();
        exp = pack(1, 1, 32'hD000_0000, 32'hDEAD_BEEF, 0, 0, 1, 1,
                   ovf_exp, 0);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL rst_pre_s0: got %h expected %h", obs, exp);
        end
        pkt_valid_in = 1'b0;
        slot_phase   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        ovf_exp = 1'b0;
        exp = pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL rst_async: got %h expected %h", obs, exp);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            slot_phase = (i % 2 == 0);
            tick();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rst_no_stale[%0d]: got %h expected %h",
                         i, obs, exp);
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        ovf_exp      = 1'b0;
        rst_n        = 1'b0;
        slot_phase   = 1'b0;
        pkt_valid_in = 1'b0;
        pkt_retry_in = 1'b0;
        pkt_in       = '0;
        edc_in       = '0;
        temp_req     = 1'b0;
        temp_data_in = '0;
        test_reset();
        test_pkt_stream();
        test_full_fifo();
        test_temp_only();
        test_starvation();
        test_phase_loss();
        test_reset_mid_slot();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
